// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: packs big-endian bytes into
// 32-bit words, writes them at consecutive indices, and holds the CPU meanwhile.
module imem_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_words,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_buf_q, word_buf_d;

    logic              byte_ready_q, byte_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              cpu_hold_q, cpu_hold_d;

    logic              byte_accept;
    logic              last_word;

    // Handshake: a byte transfers on a rising edge where byte_valid and
    // byte_ready are both high; an unaccepted byte must be held by the source.
    assign byte_accept = (state_q == S_RECV) && byte_valid && byte_ready_q;
    assign last_word   = (CNT_W'(word_idx_q) == (num_q - CNT_W'(1)));

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        word_buf_d = word_buf_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        error_d    = 1'b0;
        cpu_hold_d = cpu_hold_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (num_words == '0) begin
                        state_d    = S_DONE;
                        cpu_hold_d = 1'b0;
                    end else if (num_words > CNT_W'(DEPTH)) begin
                        error_d = 1'b1;
                    end else begin
                        state_d    = S_RECV;
                        num_d      = num_words;
                        word_idx_d = '0;
                        byte_idx_d = '0;
                        word_buf_d = '0;
                        cpu_hold_d = 1'b1;
                    end
                end
            end
            S_RECV: begin
                if (byte_accept) begin
                    case (byte_idx_q)
                        2'd0:    word_buf_d[31:24] = byte_in;
                        2'd1:    word_buf_d[23:16] = byte_in;
                        2'd2:    word_buf_d[15:8]  = byte_in;
                        default: word_buf_d[7:0]   = byte_in;
                    endcase
                    if (byte_idx_q == 2'd3) begin
                        // Last byte goes straight into the write register so
                        // the strobe lands in the very next cycle.
                        state_d    = S_WRITE;
                        wr_en_d    = 1'b1;
                        wr_addr_d  = word_idx_q;
                        wr_data_d  = {word_buf_q[31:8], byte_in};
                        byte_idx_d = '0;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            S_WRITE: begin
                if (last_word) begin
                    state_d    = S_DONE;
                    cpu_hold_d = 1'b0;
                end else begin
                    state_d    = S_RECV;
                    word_idx_d = word_idx_q + ADDR_W'(1);
                    byte_idx_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        byte_ready_d = (state_d == S_RECV);
        busy_d       = (state_d == S_RECV) || (state_d == S_WRITE);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            num_q        <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            word_buf_q   <= '0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_hold_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            word_buf_q   <= word_buf_d;
            byte_ready_q <= byte_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            cpu_hold_q   <= cpu_hold_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign cpu_hold   = cpu_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: scenario tasks drive byte streams, expected writes
// are queued as stimulus is sent and popped when wr_en appears.
module tb_imem_loader;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [CNT_W-1:0]  num_words;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              done;
    logic              error;
    logic              cpu_hold;

    int checks   = 0;
    int errors   = 0;
    int wr_count = 0;
    logic [ADDR_W+31:0] exp_q[$];
    logic [ADDR_W+31:0] exp;
    logic [31:0] basic_w [2] = '{32'h8C010004, 32'hAC020008};

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .done(done), .error(error), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_en === 1'b1) wr_count <= wr_count + 1;

    initial begin
        #100000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (byte_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL byte_ready_timeout got=%b exp=1", byte_ready);
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit toggle);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[31-8*k -: 8]);
            if (toggle && k < 3) begin
                byte_valid = 1'b0;
                checks++;
                if (byte_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_while_idle got=%b exp=1", byte_ready);
                end
                @(negedge clk);
            end
        end
        if (toggle) byte_valid = 1'b0;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] n);
        start     = 1'b1;
        num_words = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_reset();
        byte_valid = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({byte_ready, wr_en, busy, done, error, cpu_hold} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=000001", {byte_ready, wr_en, busy, done, error, cpu_hold});
        end
        checks++;
        if ({wr_addr, wr_data} !== '0) begin
            errors++;
            $display("FAIL reset_wr_bus got=%0d/%h exp=0/00000000", wr_addr, wr_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic(input bit toggle);
        do_start(2);
        checks++;
        if ({busy, byte_ready, cpu_hold, done} !== 4'b1110) begin
            errors++;
            $display("FAIL start_flags got=%b exp=1110", {busy, byte_ready, cpu_hold, done});
        end
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({ADDR_W'(i), basic_w[i]});
            send_word(basic_w[i], toggle);
            exp = exp_q.pop_front();
            checks++;
            if (wr_en !== 1'b1 || {wr_addr, wr_data} !== exp) begin
                errors++;
                $display("FAIL basic_write en=%b got=%0d/%h exp=%0d/%h", wr_en, wr_addr, wr_data,
                         exp[ADDR_W+31:32], exp[31:0]);
            end
            checks++;
            if (byte_ready !== 1'b0) begin
                errors++;
                $display("FAIL ready_in_write got=%b exp=0", byte_ready);
            end
        end
        byte_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({done, cpu_hold, busy, wr_en} !== 4'b1000) begin
            errors++;
            $display("FAIL basic_done got=%b exp=1000", {done, cpu_hold, busy, wr_en});
        end
        checks++;
        if (wr_addr !== 5'd1 || wr_data !== 32'hAC020008) begin
            errors++;
            $display("FAIL wr_bus_hold got=%0d/%h exp=1/ac020008", wr_addr, wr_data);
        end
    endtask

    task automatic test_full();
        int wc0;
        do_start(CNT_W'(DEPTH));
        wc0 = wr_count;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back({ADDR_W'(i), 32'(i)});
            send_word(32'(i), 1'b0);
            exp = exp_q.pop_front();
            checks++;
            if (wr_en !== 1'b1 || {wr_addr, wr_data} !== exp) begin
                errors++;
                $display("FAIL full_write en=%b got=%0d/%h exp=%0d/%h", wr_en, wr_addr, wr_data,
                         exp[ADDR_W+31:32], exp[31:0]);
            end
        end
        byte_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (wr_count - wc0 !== DEPTH) begin
            errors++;
            $display("FAIL full_write_count got=%0d exp=%0d", wr_count - wc0, DEPTH);
        end
        checks++;
        if ({done, cpu_hold} !== 2'b10 || wr_addr !== 5'd31 || wr_data !== 32'h1F) begin
            errors++;
            $display("FAIL full_end got=%b %0d/%h exp=10 31/0000001f", {done, cpu_hold}, wr_addr, wr_data);
        end
    endtask

    task automatic test_bad_count();
        int wc0;
        pulse_reset();
        do_start(6'd33);
        checks++;
        if ({error, busy, done, cpu_hold, byte_ready} !== 5'b10010) begin
            errors++;
            $display("FAIL over_depth got=%b exp=10010", {error, busy, done, cpu_hold, byte_ready});
        end
        @(negedge clk);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL error_one_cycle got=%b exp=0", error);
        end
        wc0 = wr_count;
        do_start(6'd0);
        checks++;
        if ({done, cpu_hold, busy} !== 3'b100) begin
            errors++;
            $display("FAIL zero_words got=%b exp=100", {done, cpu_hold, busy});
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_count !== wc0) begin
            errors++;
            $display("FAIL zero_words_writes got=%0d exp=%0d", wr_count - wc0, 0);
        end
        do_start(6'd40);
        checks++;
        if ({error, done, cpu_hold, busy} !== 4'b1100) begin
            errors++;
            $display("FAIL over_depth_done got=%b exp=1100", {error, done, cpu_hold, busy});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_start(3);
        exp_q.push_back({ADDR_W'(0), 32'h11223344});
        send_word(32'h11223344, 1'b0);
        exp = exp_q.pop_front();
        checks++;
        if (wr_en !== 1'b1 || {wr_addr, wr_data} !== exp) begin
            errors++;
            $display("FAIL mid_first_write en=%b got=%0d/%h exp=0/11223344", wr_en, wr_addr, wr_data);
        end
        send_byte(8'h55);
        send_byte(8'h66);
        pulse_reset();
        checks++;
        if ({byte_ready, wr_en, busy, done, error, cpu_hold} !== 6'b000001 || {wr_addr, wr_data} !== '0) begin
            errors++;
            $display("FAIL mid_reset got=%b %0d/%h exp=000001 0/00000000",
                     {byte_ready, wr_en, busy, done, error, cpu_hold}, wr_addr, wr_data);
        end
        do_start(1);
        exp_q.push_back({ADDR_W'(0), 32'hA1B2C3D4});
        send_word(32'hA1B2C3D4, 1'b0);
        exp = exp_q.pop_front();
        checks++;
        if (wr_en !== 1'b1 || {wr_addr, wr_data} !== exp) begin
            errors++;
            $display("FAIL after_reset_write en=%b got=%0d/%h exp=0/a1b2c3d4", wr_en, wr_addr, wr_data);
        end
        byte_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        do_start(2);
        exp_q.push_back({ADDR_W'(0), 32'hDEADBEEF});
        exp_q.push_back({ADDR_W'(1), 32'h0BADF00D});
        send_byte(8'hDE);
        byte_valid = 1'b0;
        do_start(1);
        checks++;
        if ({error, busy, byte_ready} !== 3'b011) begin
            errors++;
            $display("FAIL start_in_recv got=%b exp=011", {error, busy, byte_ready});
        end
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        for (int i = 0; i < 2; i++) begin
            if (i == 1) send_word(32'h0BADF00D, 1'b0);
            exp = exp_q.pop_front();
            checks++;
            if (wr_en !== 1'b1 || {wr_addr, wr_data} !== exp) begin
                errors++;
                $display("FAIL ignored_start_write en=%b got=%0d/%h exp=%0d/%h", wr_en, wr_addr, wr_data,
                         exp[ADDR_W+31:32], exp[31:0]);
            end
        end
        byte_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({done, cpu_hold} !== 2'b10) begin
            errors++;
            $display("FAIL ignored_start_done got=%b exp=10", {done, cpu_hold});
        end
        do_start(1);
        checks++;
        if ({cpu_hold, done, busy} !== 3'b101) begin
            errors++;
            $display("FAIL restart_flags got=%b exp=101", {cpu_hold, done, busy});
        end
        exp_q.push_back({ADDR_W'(0), 32'hCAFEBABE});
        send_word(32'hCAFEBABE, 1'b1);
        exp = exp_q.pop_front();
        checks++;
        if (wr_en !== 1'b1 || {wr_addr, wr_data} !== exp) begin
            errors++;
            $display("FAIL restart_write en=%b got=%0d/%h exp=0/cafebabe", wr_en, wr_addr, wr_data);
        end
        @(negedge clk);
        checks++;
        if ({done, cpu_hold} !== 2'b10) begin
            errors++;
            $display("FAIL restart_done got=%b exp=10", {done, cpu_hold});
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        num_words  = '0;
        byte_in    = '0;
        byte_valid = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_full();
        test_bad_count();
        test_reset_mid();
        test_start_ignored();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
